// File: rtl/ahb_sel_path.sv
// AHB address-select path: A/B address regs, source mux,
// region decoder, data-phase selects, ERROR default slave.
//
// Ports:
//   clk, rst            clock, sync active-high reset
//   haddr_a/load_a      address source A and its load strobe
//   haddr_b/load_b      address source B and its load strobe
//   src_sel             0 = reg A drives decode, 1 = reg B
//   htrans, hready_in   address-phase transfer type / bus ready
//   addr_out            selected address
//   hsel, hsel_dflt     address-phase slave / default selects
//   dp_sel, dp_dflt     registered data-phase selects
//   dflt_hready         default slave HREADYOUT
//   dflt_hresp          default slave HRESP (1 = ERROR)
//   err_cnt             saturating count of ERROR responses
module ahb_sel_path #(
  parameter int ADDR_W     = 16,
  parameter int NUM_SLV    = 3,
  parameter int REGION_LSB = 12,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] haddr_a,
  input  logic              load_a,
  input  logic [ADDR_W-1:0] haddr_b,
  input  logic              load_b,
  input  logic              src_sel,
  input  logic [1:0]        htrans,
  input  logic              hready_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [NUM_SLV-1:0] hsel,
  output logic              hsel_dflt,
  output logic [NUM_SLV-1:0] dp_sel,
  output logic              dp_dflt,
  output logic              dflt_hready,
  output logic              dflt_hresp,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int IW = ADDR_W - REGION_LSB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ERR1 = 2'd1,
    S_ERR2 = 2'd2
  } ds_state_t;

  logic [ADDR_W-1:0] reg_a;
  logic [ADDR_W-1:0] reg_b;
  logic [IW-1:0]     idx;
  logic              q_xfer;
  ds_state_t         state_q;
  ds_state_t         state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      if (load_a) reg_a <= haddr_a;
      if (load_b) reg_b <= haddr_b;
    end
  end

  assign addr_out = src_sel ? reg_b : reg_a;
  assign idx      = addr_out[ADDR_W-1:REGION_LSB];

  // Anything past the last mapped region falls to
  // the default slave.
  always_comb begin
    hsel      = '0;
    hsel_dflt = 1'b0;
    if (!rst) begin
      hsel_dflt = 1'b1;
      for (int i = 0; i < NUM_SLV; i++) begin
        if (idx == IW'(i)) begin
          hsel[i]   = 1'b1;
          hsel_dflt = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sel  <= '0;
      dp_dflt <= 1'b0;
    end else if (hready_in) begin
      dp_sel  <= hsel;
      dp_dflt <= hsel_dflt;
    end
  end

  // Only NONSEQ/SEQ (htrans[1]) to unmapped space errors.
  assign q_xfer = hready_in & hsel_dflt & htrans[1];

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    dflt_hready = 1'b1;
    dflt_hresp  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (q_xfer) state_d = S_ERR1;
      end
      S_ERR1: begin
        dflt_hready = 1'b0;
        dflt_hresp  = 1'b1;
        state_d     = S_ERR2;
      end
      S_ERR2: begin
        dflt_hresp = 1'b1;
        state_d    = q_xfer ? S_ERR1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ERR1 is never re-entered from itself, so every
  // transition into it is a fresh ERROR response.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (state_d == S_ERR1 &&
                 err_cnt != {CNT_W{1'b1}}) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_sel_path.sv
// Directed bench for ahb_sel_path: default instance
// plus a CNT_W=2 instance for counter saturation.
module tb_ahb_sel_path;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] haddr_a, haddr_b;
  logic        load_a, load_b, src_sel;
  logic [1:0]  htrans;
  logic        hready_in;

  logic [15:0] addr_out, addr_out2;
  logic [2:0]  hsel, hsel2, dp_sel, dp_sel2;
  logic        hsel_dflt, hsel_dflt2, dp_dflt, dp_dflt2;
  logic        dflt_hready, dflt_hready2;
  logic        dflt_hresp, dflt_hresp2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ahb_sel_path dut (
    .clk(clk), .rst(rst),
    .haddr_a(haddr_a), .load_a(load_a),
    .haddr_b(haddr_b), .load_b(load_b),
    .src_sel(src_sel), .htrans(htrans),
    .hready_in(hready_in), .addr_out(addr_out),
    .hsel(hsel), .hsel_dflt(hsel_dflt),
    .dp_sel(dp_sel), .dp_dflt(dp_dflt),
    .dflt_hready(dflt_hready),
    .dflt_hresp(dflt_hresp), .err_cnt(err_cnt)
  );

  ahb_sel_path #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .haddr_a(haddr_a), .load_a(load_a),
    .haddr_b(haddr_b), .load_b(load_b),
    .src_sel(src_sel), .htrans(htrans),
    .hready_in(hready_in), .addr_out(addr_out2),
    .hsel(hsel2), .hsel_dflt(hsel_dflt2),
    .dp_sel(dp_sel2), .dp_dflt(dp_dflt2),
    .dflt_hready(dflt_hready2),
    .dflt_hresp(dflt_hresp2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_ds(input string tag,
                        input logic rdy,
                        input logic resp,
                        input int cnt);
    chk({tag, "_rdy"}, 32'(dflt_hready), 32'(rdy));
    chk({tag, "_resp"}, 32'(dflt_hresp), 32'(resp));
    chk({tag, "_cnt"}, 32'(err_cnt), 32'(cnt));
  endtask

  logic [15:0] sw_addr [6];
  logic [2:0]  sw_hsel [6];
  logic        sw_dflt [6];

  initial begin
    sw_addr = '{16'h0000, 16'h0FFF, 16'h1000,
                16'h2ABC, 16'h3000, 16'hFFFF};
    sw_hsel = '{3'b001, 3'b001, 3'b010,
                3'b100, 3'b000, 3'b000};
    sw_dflt = '{1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    haddr_a = 16'h1234; load_a = 1'b1;
    haddr_b = 16'h5678; load_b = 1'b1;
    src_sel = 1'b0; htrans = 2'b00;
    hready_in = 1'b1;

    // reset with loads active
    step(); step();
    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_hsel", 32'(hsel), 32'h0);
    chk("rst_hdflt", 32'(hsel_dflt), 32'h0);
    chk("rst_dp", 32'(dp_sel), 32'h0);
    chk_ds("rst", 1'b1, 1'b0, 0);
    chk("rst_cnt2", 32'(err_cnt2), 32'h0);
    rst = 1'b0; load_a = 1'b0; load_b = 1'b0;
    #1;
    chk("post_rst_hsel", 32'(hsel), 32'h1);
    chk("post_rst_hdflt", 32'(hsel_dflt), 32'h0);
    src_sel = 1'b1;
    #1;
    chk("post_rst_b", 32'(addr_out), 32'h0);
    src_sel = 1'b0;

    // map sweep, IDLE transfers
    for (int i = 0; i < 6; i++) begin
      haddr_a = sw_addr[i]; load_a = 1'b1;
      step();
      load_a = 1'b0;
      chk($sformatf("map_hsel%0d", i),
          32'(hsel), 32'(sw_hsel[i]));
      chk($sformatf("map_dflt%0d", i),
          32'(hsel_dflt), 32'(sw_dflt[i]));
    end
    step();
    chk_ds("idle_unmapped", 1'b1, 1'b0, 0);

    // source mux, simultaneous loads
    haddr_a = 16'h1000; load_a = 1'b1;
    haddr_b = 16'h2000; load_b = 1'b1;
    step();
    load_a = 1'b0; load_b = 1'b0;
    chk("mux_a_addr", 32'(addr_out), 32'h1000);
    chk("mux_a_hsel", 32'(hsel), 32'h2);
    src_sel = 1'b1; #1;
    chk("mux_b_addr", 32'(addr_out), 32'h2000);
    chk("mux_b_hsel", 32'(hsel), 32'h4);
    src_sel = 1'b0; #1;
    chk("mux_a2_hsel", 32'(hsel), 32'h2);

    // data phase held through wait states
    htrans = 2'b10; hready_in = 1'b1;
    step();
    chk("dp_acc", 32'(dp_sel), 32'h2);
    htrans = 2'b00; hready_in = 1'b0;
    haddr_a = 16'h2000; load_a = 1'b1;
    step();
    load_a = 1'b0;
    chk("dp_w1_hsel", 32'(hsel), 32'h4);
    chk("dp_w1", 32'(dp_sel), 32'h2);
    step();
    chk("dp_w2", 32'(dp_sel), 32'h2);
    step();
    chk("dp_w3", 32'(dp_sel), 32'h2);
    hready_in = 1'b1;
    step();
    chk("dp_rel", 32'(dp_sel), 32'h4);
    chk("dp_rel_dflt", 32'(dp_dflt), 32'h0);

    // single error to 0x4000
    haddr_a = 16'h4000; load_a = 1'b1;
    step();
    load_a = 1'b0;
    chk("ds_hdflt", 32'(hsel_dflt), 32'h1);
    chk_ds("ds_pre", 1'b1, 1'b0, 0);
    htrans = 2'b10;
    step();
    htrans = 2'b00;
    chk_ds("ds_err1", 1'b0, 1'b1, 1);
    chk("ds_dpdflt", 32'(dp_dflt), 32'h1);
    chk("ds_dpsel", 32'(dp_sel), 32'h0);
    step();
    chk_ds("ds_err2", 1'b1, 1'b1, 1);
    step();
    chk_ds("ds_idle", 1'b1, 1'b0, 1);
    step();
    chk_ds("ds_idle_tr", 1'b1, 1'b0, 1);
    htrans = 2'b01;
    step();
    chk_ds("ds_busy_tr", 1'b1, 1'b0, 1);

    // back-to-back errors; hready_in ignored in ERR1
    htrans = 2'b10;
    step();
    chk_ds("bb_err1a", 1'b0, 1'b1, 2);
    hready_in = 1'b0;
    step();
    chk_ds("bb_err2a", 1'b1, 1'b1, 2);
    hready_in = 1'b1;
    step();
    chk_ds("bb_err1b", 1'b0, 1'b1, 3);
    chk("bb_cnt2_3", 32'(err_cnt2), 32'h3);
    step();
    chk_ds("bb_err2b", 1'b1, 1'b1, 3);
    step();
    chk_ds("bb_err1c", 1'b0, 1'b1, 4);
    chk("sat_cnt2_4", 32'(err_cnt2), 32'h3);
    step();
    step();
    chk_ds("bb_err1d", 1'b0, 1'b1, 5);
    chk("sat_cnt2_5", 32'(err_cnt2), 32'h3);

    // reset while in ERR1
    rst = 1'b1; htrans = 2'b00;
    #1;
    chk("mid_rst_hsel", 32'(hsel_dflt), 32'h0);
    step();
    chk_ds("mid_rst", 1'b1, 1'b0, 0);
    chk("mid_rst_cnt2", 32'(err_cnt2), 32'h0);
    chk("mid_rst_addr", 32'(addr_out), 32'h0);
    rst = 1'b0;
    step();
    chk_ds("after_rst", 1'b1, 1'b0, 0);
    chk("after_rst_hsel", 32'(hsel), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
